// File: rtl/srm_arb_pkg.sv
// Shared definitions for the battery-SRAM arbiter: FSM encoding, CPU window
// decode and the minimum access-length constant.
package srm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_SYS  = 2'd2
  } arb_state_t;

  localparam logic [15:0] WIN_BASE    = 16'h6000;
  localparam logic [2:0]  WIN_TAG     = WIN_BASE[15:13];
  localparam int          ACC_CYC_MIN = 3;

  // $6000-$7FFF is selected by the top three address bits alone.
  function automatic logic is_hit(input logic [15:0] addr);
    return addr[15:13] == WIN_TAG;
  endfunction

endpackage

// File: rtl/m2_sync.sv
// Brings the raw CPU M2 strobe into the clk domain and derives single-cycle
// rise/fall pulses from the synchronized level.
module m2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic m2_s,
  output logic m2_rise,
  output logic m2_fall
);

  logic m2_meta_reg;
  logic m2_sync_reg;
  logic m2_dly_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta_reg <= 1'b0;
      m2_sync_reg <= 1'b0;
      m2_dly_reg  <= 1'b0;
    end else begin
      m2_meta_reg <= m2;
      m2_sync_reg <= m2_meta_reg;
      m2_dly_reg  <= m2_sync_reg;
    end
  end

  assign m2_s    = m2_sync_reg;
  assign m2_rise = m2_sync_reg & ~m2_dly_reg;
  assign m2_fall = ~m2_sync_reg & m2_dly_reg;

endmodule

// File: rtl/srm_arbiter.sv
// Battery-SRAM arbiter: CPU M2 cycles take priority, system req/ack traffic
// fills idle slots. Define SRM_WP_EN to add the srm_wp CPU write-protect input.
module srm_arbiter
  import srm_arb_pkg::*;
#(
  parameter int ACC_CYC = 3,
  parameter int WR_DLY  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdat,
`ifdef SRM_WP_EN
  input  logic        srm_wp,
`endif
  output logic [7:0]  cpu_rdat,
  input  logic        sys_req,
  input  logic        sys_we,
  input  logic [12:0] sys_addr,
  input  logic [7:0]  sys_wdat,
  output logic        sys_ack,
  output logic [7:0]  sys_rdat,
  output logic [12:0] srm_addr,
  output logic [7:0]  srm_wdat,
  input  logic [7:0]  srm_rdat,
  output logic        srm_ce,
  output logic        srm_oe,
  output logic        srm_we,
  output logic        busy
);

  localparam int              CW       = $clog2(ACC_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ACC_CYC - 1);
  localparam logic [CW-1:0]   CNT_CAP  = CW'(ACC_CYC - 2);
  localparam int              HW       = $clog2(WR_DLY + 1);
  localparam logic [HW-1:0]   HI_TRIG  = HW'(WR_DLY - 1);
  localparam logic [HW-1:0]   HI_MAX   = HW'(WR_DLY);

  if (ACC_CYC < ACC_CYC_MIN) begin : g_acc_cyc_check
    $error("srm_arbiter: ACC_CYC must be at least %0d", ACC_CYC_MIN);
  end

  logic            m2_s, m2_rise, m2_fall;
  arb_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [HW-1:0]   hi_cnt_reg;
  logic            served_reg, cpu_pend_reg, cpu_rd_reg;
  logic [12:0]     cpu_addr_reg;
  logic [7:0]      cpu_wdat_reg;
  logic            acc_rd_reg, acc_rd_next;
  logic            cpu_hit, rd_trig, wr_trig, wr_go, acc_start, rd_cap;
  logic [12:0]     srm_addr_next;
  logic [7:0]      srm_wdat_next, cpu_rdat_next, sys_rdat_next;
  logic            srm_ce_next, srm_oe_next, srm_we_next, sys_ack_next, busy_next;

  m2_sync u_m2_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .m2      (m2),
    .m2_s    (m2_s),
    .m2_rise (m2_rise),
    .m2_fall (m2_fall)
  );

  assign cpu_hit = is_hit(cpu_addr);
  assign rd_trig = m2_rise & cpu_hit & cpu_rw & ~served_reg;
  // Writes wait until M2 has been high long enough for the CPU data to settle.
  assign wr_trig = m2_s & (hi_cnt_reg == HI_TRIG) & cpu_hit & ~cpu_rw & ~served_reg;
`ifdef SRM_WP_EN
  assign wr_go   = wr_trig & ~srm_wp;
`else
  assign wr_go   = wr_trig;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_reg   <= 1'b0;
      hi_cnt_reg   <= '0;
      cpu_pend_reg <= 1'b0;
      cpu_rd_reg   <= 1'b0;
      cpu_addr_reg <= '0;
      cpu_wdat_reg <= '0;
    end else begin
      if (m2_fall)
        served_reg <= 1'b0;
      else if (rd_trig | wr_trig)
        served_reg <= 1'b1;

      if (!m2_s)
        hi_cnt_reg <= '0;
      else if (hi_cnt_reg != HI_MAX)
        hi_cnt_reg <= hi_cnt_reg + 1'b1;

      if (rd_trig | wr_go) begin
        cpu_pend_reg <= 1'b1;
        cpu_rd_reg   <= rd_trig;
        cpu_addr_reg <= cpu_addr[12:0];
        cpu_wdat_reg <= cpu_wdat;
      end else if (acc_start && state_next == ST_CPU) begin
        cpu_pend_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_rd_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_rd_reg <= acc_rd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (cpu_pend_reg)
          state_next = ST_CPU;
        else if (sys_req)
          state_next = ST_SYS;
      end
      default: begin
        if (cnt_reg == CNT_LAST)
          state_next = ST_IDLE;
        else
          cnt_next = cnt_reg + 1'b1;
      end
    endcase
  end

  // Everything below feeds the output registers, so it is phrased in terms of
  // the state and cycle count the arbiter will be in after the next edge.
  always_comb begin
    acc_start     = (state_reg == ST_IDLE) && (state_next != ST_IDLE);
    acc_rd_next   = acc_rd_reg;
    srm_addr_next = srm_addr;
    srm_wdat_next = srm_wdat;
    if (acc_start) begin
      if (state_next == ST_CPU) begin
        acc_rd_next   = cpu_rd_reg;
        srm_addr_next = cpu_addr_reg;
        srm_wdat_next = cpu_wdat_reg;
      end else begin
        acc_rd_next   = ~sys_we;
        srm_addr_next = sys_addr;
        srm_wdat_next = sys_wdat;
      end
    end
    srm_ce_next  = (state_next != ST_IDLE);
    srm_oe_next  = srm_ce_next & acc_rd_next;
    srm_we_next  = srm_ce_next & ~acc_rd_next & (cnt_next != '0) & (cnt_next <= CNT_CAP);
    sys_ack_next = (state_next == ST_SYS) && (cnt_next == CNT_LAST);
    busy_next    = srm_ce_next;

    // Capture on the edge that enters the last cycle so sys_rdat is already
    // valid while sys_ack is high.
    rd_cap        = (state_reg != ST_IDLE) && (cnt_reg == CNT_CAP) && acc_rd_reg;
    cpu_rdat_next = cpu_rdat;
    sys_rdat_next = sys_rdat;
    if (rd_cap) begin
      if (state_reg == ST_CPU)
        cpu_rdat_next = srm_rdat;
      else
        sys_rdat_next = srm_rdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srm_addr <= '0;
      srm_wdat <= '0;
      srm_ce   <= 1'b0;
      srm_oe   <= 1'b0;
      srm_we   <= 1'b0;
      sys_ack  <= 1'b0;
      busy     <= 1'b0;
      cpu_rdat <= 8'hFF;
      sys_rdat <= 8'h00;
    end else begin
      srm_addr <= srm_addr_next;
      srm_wdat <= srm_wdat_next;
      srm_ce   <= srm_ce_next;
      srm_oe   <= srm_oe_next;
      srm_we   <= srm_we_next;
      sys_ack  <= sys_ack_next;
      busy     <= busy_next;
      cpu_rdat <= cpu_rdat_next;
      sys_rdat <= sys_rdat_next;
    end
  end

endmodule

// File: tb/tb_srm_arbiter.sv
// Scoreboard bench for srm_arbiter: stimulus pushes expected SRAM transactions,
// a bus monitor reconstructs each access from the SRAM pins and compares.
module tb_srm_arbiter;

  localparam int ACC = 3;
  localparam int WRD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_wdat = '0;
  logic [7:0]  cpu_rdat;
  logic        sys_req = 1'b0;
  logic        sys_we = 1'b0;
  logic [12:0] sys_addr = '0;
  logic [7:0]  sys_wdat = '0;
  logic        sys_ack;
  logic [7:0]  sys_rdat;
  logic [12:0] srm_addr;
  logic [7:0]  srm_wdat;
  logic [7:0]  srm_rdat;
  logic        srm_ce, srm_oe, srm_we, busy;
`ifdef SRM_WP_EN
  logic        srm_wp = 1'b0;
`endif

  always #5 clk = ~clk;

  srm_arbiter #(.ACC_CYC(ACC), .WR_DLY(WRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m2       (m2),
    .cpu_addr (cpu_addr),
    .cpu_rw   (cpu_rw),
    .cpu_wdat (cpu_wdat),
`ifdef SRM_WP_EN
    .srm_wp   (srm_wp),
`endif
    .cpu_rdat (cpu_rdat),
    .sys_req  (sys_req),
    .sys_we   (sys_we),
    .sys_addr (sys_addr),
    .sys_wdat (sys_wdat),
    .sys_ack  (sys_ack),
    .sys_rdat (sys_rdat),
    .srm_addr (srm_addr),
    .srm_wdat (srm_wdat),
    .srm_rdat (srm_rdat),
    .srm_ce   (srm_ce),
    .srm_oe   (srm_oe),
    .srm_we   (srm_we),
    .busy     (busy)
  );

  // SRAM model, preloaded with addr[7:0]^A5 plus two directed cells.
  logic [7:0] mem [8192];
  logic       loaded = 1'b0;
  assign srm_rdat = (srm_ce && srm_oe) ? mem[srm_addr] : 8'h00;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem[13'h0123] <= 8'h5A;
      mem[13'h0010] <= 8'h77;
      loaded <= 1'b1;
    end else if (srm_ce && srm_we) begin
      mem[srm_addr] <= srm_wdat;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  data;
    int          oe_len;
    int          we_len;
    int          we_off;
    int          ack;
    int          smin;
    int          smax;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  data;
    int          oe_len;
    int          we_len;
    int          we_off;
    int          ack;
    int          start;
    logic        moved;
  } obs_t;

  exp_t cpu_q[$];
  exp_t sys_q[$];
  int   total = 0;
  int   bad = 0;
  int   acks = 0;
  int   exp_acks = 0;
  int   acc_cnt = 0;
  logic active = 1'b0;
  logic [7:0] rd_tbl [6] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0};

  function automatic exp_t mk(input logic wr, input logic [12:0] a, input logic [7:0] d,
                              input logic sys, input int smin, input int smax);
    exp_t e;
    e.wr     = wr;
    e.addr   = a;
    e.data   = d;
    e.oe_len = wr ? 0 : ACC;
    e.we_len = wr ? ACC - 2 : 0;
    e.we_off = wr ? 1 : 0;
    e.ack    = sys ? 1 : 0;
    e.smin   = smin;
    e.smax   = smax;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end else begin
      $display("chk %s = %h ok", nm, act);
    end
  endtask

  // Bus monitor: one record per SRAM access, closed on the idle cycle after it.
  initial begin
    obs_t cur;
    exp_t e;
    logic is_sys, ok;
    forever begin
      @(negedge clk);
      if (sys_ack) acks++;
      if (!rst_n) begin
        active = 1'b0;
      end else if (srm_ce) begin
        if (!active) begin
          active = 1'b1;
          cur = '{wr: 1'b0, addr: srm_addr, data: 8'h00, oe_len: 0, we_len: 0,
                  we_off: 0, ack: 0, start: cyc, moved: 1'b0};
        end
        if (srm_addr != cur.addr) cur.moved = 1'b1;
        if (srm_oe) cur.oe_len++;
        if (srm_we) begin
          if (cur.we_len == 0) cur.we_off = cyc - cur.start;
          cur.we_len++;
          cur.wr = 1'b1;
          cur.data = srm_wdat;
        end
        if (sys_ack) cur.ack++;
      end else if (active) begin
        active = 1'b0;
        acc_cnt++;
        is_sys = (cur.ack != 0);
        if (!cur.wr) cur.data = is_sys ? sys_rdat : cpu_rdat;
        total++;
        if ((is_sys && sys_q.size() == 0) || (!is_sys && cpu_q.size() == 0)) begin
          bad++;
          $display("FAIL txn_unexpected got wr=%0b addr=%h data=%h start=%0d ack=%0d want none",
                   cur.wr, cur.addr, cur.data, cur.start, cur.ack);
        end else begin
          e = is_sys ? sys_q.pop_front() : cpu_q.pop_front();
          ok = (e.wr == cur.wr) && (e.addr == cur.addr) && (e.data == cur.data) &&
               (e.oe_len == cur.oe_len) && (e.we_len == cur.we_len) &&
               (!e.wr || e.we_off == cur.we_off) && (e.ack == cur.ack) &&
               (cur.start >= e.smin) && (cur.start <= e.smax) && !cur.moved;
          if (!ok) begin
            bad++;
            $display("FAIL txn_%s got wr=%0b addr=%h data=%h start=%0d oe=%0d we=%0d@%0d ack=%0d moved=%0b want wr=%0b addr=%h data=%h start=%0d..%0d oe=%0d we=%0d@%0d ack=%0d",
                     is_sys ? "sys" : "cpu", cur.wr, cur.addr, cur.data, cur.start, cur.oe_len,
                     cur.we_len, cur.we_off, cur.ack, cur.moved, e.wr, e.addr, e.data, e.smin,
                     e.smax, e.oe_len, e.we_len, e.we_off, e.ack);
          end else begin
            $display("txn %s %s addr=%h data=%h start=%0d ok", is_sys ? "sys" : "cpu",
                     cur.wr ? "wr" : "rd", cur.addr, cur.data, cur.start);
          end
        end
      end
    end
  end

  // One M2 cycle; a hit pushes the expected access with its start-cycle window.
  task automatic m2_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          input logic hit, input logic [7:0] rd_exp, input int slack,
                          input int hi, input int lo);
    int c, s;
    @(posedge clk); #1;
    c = cyc;
    cpu_addr = a;
    cpu_rw = rw;
    cpu_wdat = wd;
    m2 = 1'b1;
    if (hit) begin
      s = rw ? c + 4 : c + WRD + 3;
      cpu_q.push_back(mk(!rw, a[12:0], rw ? rd_exp : wd, 1'b0, s, s + slack));
    end
    repeat (hi) @(posedge clk);
    #1 m2 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic sys_issue(input logic we, input logic [12:0] a, input logic [7:0] d,
                           input int smin, input int smax);
    sys_we = we;
    sys_addr = a;
    sys_wdat = d;
    sys_req = 1'b1;
    exp_acks++;
    sys_q.push_back(mk(we, a, d, 1'b1, smin, smax));
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sys_ack && n < 200);
    if (!sys_ack) begin
      total++;
      bad++;
      $display("FAIL %s_ack_timeout: got no ack want ack within 200 cycles", nm);
    end
  endtask

  task automatic sys_op(input logic we, input logic [12:0] a, input logic [7:0] d,
                        input int smin, input int smax);
    sys_issue(we, a, d, smin, smax);
    wait_ack("sys_op");
    sys_req = 1'b0;
  endtask

  // Request held high throughout; the next write is presented right after each ack.
  task automatic sys_burst(input int n);
    for (int i = 0; i < n; i++) begin
      sys_issue(1'b1, 13'(13'h100 + i), 8'(8'h30 + i), 0, 32'h7fffffff);
      wait_ack("burst");
    end
    sys_req = 1'b0;
  endtask

  initial begin
    int n;
    int a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 32'(srm_ce), 32'h0);
    chk("rst_oe", 32'(srm_oe), 32'h0);
    chk("rst_we", 32'(srm_we), 32'h0);
    chk("rst_addr", 32'(srm_addr), 32'h0);
    chk("rst_wdat", 32'(srm_wdat), 32'h0);
    chk("rst_cpu_rdat", 32'(cpu_rdat), 32'hFF);
    chk("rst_sys_rdat", 32'(sys_rdat), 32'h0);
    chk("rst_ack", 32'(sys_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    m2_cycle(16'h6123, 1'b1, 8'h00, 1'b1, 8'h5A, 0, 10, 6);
    chk("t1_cpu_rdat", 32'(cpu_rdat), 32'h5A);
    chk("t1_no_ack", 32'(acks), 32'h0);

    m2_cycle(16'h7FFF, 1'b0, 8'hC3, 1'b1, 8'h00, 0, 20, 6);
    m2_cycle(16'h7FFF, 1'b1, 8'h00, 1'b1, 8'hC3, 0, 10, 6);

    a0 = acc_cnt;
    m2_cycle(16'h8000, 1'b1, 8'h00, 1'b0, 8'h00, 0, 10, 6);
    m2_cycle(16'h5FFF, 1'b0, 8'h11, 1'b0, 8'h00, 0, 20, 6);
    chk("miss_no_access", 32'(acc_cnt), 32'(a0));
    m2_cycle(16'h6000, 1'b1, 8'h00, 1'b1, 8'hA5, 0, 10, 6);

    // sys_req rises in the same cycle cpu_pend does: CPU first, SYS 3+1+3 later.
    fork
      m2_cycle(16'h6321, 1'b1, 8'h00, 1'b1, 8'h84, 0, 16, 6);
      begin
        repeat (4) @(posedge clk);
        #1;
        sys_op(1'b0, 13'h0010, 8'h77, cyc + 5, cyc + 5);
      end
    join
    chk("t3_sys_rdat", 32'(sys_rdat), 32'h77);

    fork
      sys_burst(12);
      begin
        for (int k = 0; k < 6; k++)
          m2_cycle(16'h6200 + 16'(k), 1'b1, 8'h00, 1'b1, rd_tbl[k], ACC, 10, 6);
      end
    join
    sys_op(1'b0, 13'h0105, 8'h35, 0, 32'h7fffffff);
    m2_cycle(16'h6100, 1'b1, 8'h00, 1'b1, 8'h30, 0, 10, 6);

    // Abort a system read in its second access cycle.
    @(negedge clk);
    sys_we = 1'b0;
    sys_addr = 13'h0040;
    sys_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!srm_ce && n < 50);
    chk("t5_sys_started", 32'(srm_ce), 32'h1);
    a0 = acks;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_ce_drop", 32'(srm_ce), 32'h0);
    chk("t5_oe_drop", 32'(srm_oe), 32'h0);
    chk("t5_we_drop", 32'(srm_we), 32'h0);
    chk("t5_busy_drop", 32'(busy), 32'h0);
    chk("t5_cpu_rdat_rst", 32'(cpu_rdat), 32'hFF);
    repeat (2) @(negedge clk);
    chk("t5_no_ack_in_rst", 32'(acks), 32'(a0));
    rst_n = 1'b1;
    sys_issue(1'b0, 13'h0040, 8'hE5, 0, 32'h7fffffff);
    wait_ack("t5");
    sys_req = 1'b0;

`ifdef SRM_WP_EN
    srm_wp = 1'b1;
    a0 = acc_cnt;
    m2_cycle(16'h6000, 1'b0, 8'h99, 1'b0, 8'h00, 0, 20, 6);
    chk("wp_no_write", 32'(acc_cnt), 32'(a0));
    sys_op(1'b1, 13'h0000, 8'h42, 0, 32'h7fffffff);
    srm_wp = 1'b0;
`endif

    for (int i = 0; i < 100 && (cpu_q.size() != 0 || sys_q.size() != 0 || active); i++)
      @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("sys_q_drained", 32'(sys_q.size()), 32'h0);
    chk("ack_count", 32'(acks), 32'(exp_acks));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
